// File: rtl/adder_result_accumulator.sv
// Accumulates blocks of LEN unsigned 26-bit adder sums into an ACC_W-bit total with a sticky overflow flag.
// Latency: the result is presented one cycle after the final sum of a block is accepted.
// Backpressure: the input stalls (IN_READY=0) while a completed result waits in HOLD for OUT_READY.
// Build option: define ADDER_RESULT_ACCUMULATOR_SATURATE_EN to clamp the total on overflow instead of wrapping.
module adder_result_accumulator #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [25:0]      IN_S,
  input  logic [CNT_W-1:0] LEN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [ACC_W-1:0] OUT_SUM,
  output logic             OUT_OVF,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] target, target_nxt;
  logic             ovf, ovf_nxt;

  // One extra bit captures the carry-out of the running addition.
  logic [ACC_W:0]   sum_ext;
  logic             carry;

  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(IN_S);
  assign carry   = sum_ext[ACC_W];

  // Next-state, datapath updates and handshake outputs, decoded from the current state.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    target_nxt = target;
    ovf_nxt    = ovf;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    BUSY       = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          // A zero length is treated as a single-sum block.
          target_nxt = (LEN == '0) ? CNT_W'(1) : LEN;
          acc_nxt    = ACC_W'(IN_S);
          cnt_nxt    = CNT_W'(1);
          ovf_nxt    = 1'b0;
          state_nxt  = (target_nxt == CNT_W'(1)) ? HOLD : ACC;
        end
      end
      ACC: begin
        IN_READY = 1'b1;
        BUSY     = 1'b1;
        if (IN_VALID) begin
          cnt_nxt = cnt + CNT_W'(1);
          ovf_nxt = ovf | carry;
`ifdef ADDER_RESULT_ACCUMULATOR_SATURATE_EN
          // Once clamped, the total stays pinned at full scale for the rest of the block.
          acc_nxt = (ovf | carry) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
          acc_nxt = sum_ext[ACC_W-1:0];
`endif
          state_nxt = (cnt_nxt == target) ? HOLD : ACC;
        end
      end
      HOLD: begin
        OUT_VALID = 1'b1;
        BUSY      = 1'b1;
        // Input is refused even in the release cycle; the next block starts from IDLE.
        if (OUT_READY) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      target <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      target <= target_nxt;
      ovf    <= ovf_nxt;
    end
  end

  assign OUT_SUM = acc;
  assign OUT_OVF = ovf;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: directed scenarios plus randomized blocks with random output stalls.
// Expected block results come from a whole-block arithmetic model and are checked by a monitor via a queue.
// Honors ADDER_RESULT_ACCUMULATOR_SATURATE_EN so the same bench checks either build.
module tb_adder_result_accumulator;

  localparam int ACC_W = 26;
  localparam int CNT_W = 8;
  localparam longint unsigned MAXV = (64'd1 << ACC_W) - 1;

  logic             CLK;
  logic             RST;
  logic             IN_VALID;
  logic             IN_READY;
  logic [25:0]      IN_S;
  logic [CNT_W-1:0] LEN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [ACC_W-1:0] OUT_SUM;
  logic             OUT_OVF;
  logic             BUSY;

  adder_result_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_S(IN_S), .LEN(LEN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SUM(OUT_SUM), .OUT_OVF(OUT_OVF), .BUSY(BUSY)
  );

  // Free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int tests = 0;
  int fails = 0;
  int n_pushed = 0;
  int n_out = 0;
  bit rand_mode = 0;

  // Reference model: tracks the block in progress as a plain running total.
  int              m_cnt = 0;
  int              m_target = 0;
  longint unsigned m_total = 0;
  longint unsigned exp_sum_q[$];
  bit              exp_ovf_q[$];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [25:0] s, input logic [CNT_W-1:0] len);
    longint unsigned res;
    bit              o;
    if (m_cnt == 0) begin
      m_target = (len == 0) ? 1 : int'(len);
      m_total  = 0;
    end
    m_total += s;
    m_cnt++;
    if (m_cnt == m_target) begin
      o = (m_total > MAXV);
`ifdef ADDER_RESULT_ACCUMULATOR_SATURATE_EN
      res = o ? MAXV : m_total;
`else
      res = m_total & MAXV;
`endif
      exp_sum_q.push_back(res);
      exp_ovf_q.push_back(o);
      n_pushed++;
      m_cnt = 0;
    end
  endtask

  // Advance one cycle; inputs change just after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_mode) OUT_READY = 1'($urandom_range(0, 1));
  endtask

  // Present one sum and hold it until it is accepted.
  task automatic send(input logic [25:0] s, input logic [CNT_W-1:0] len);
    int t = 0;
    IN_VALID = 1'b1;
    IN_S     = s;
    LEN      = len;
    while (!IN_READY && t < 200) begin
      tick();
      t++;
    end
    if (!IN_READY) begin
      check("send_timeout", 1, 0);
    end else begin
      tick();
      model_accept(s, len);
    end
    IN_VALID = 1'b0;
  endtask

  // Monitor: compares every output transfer with the queue and checks stability while stalled.
  task automatic monitor_loop();
    bit              held = 0;
    logic [ACC_W-1:0] held_sum = '0;
    logic            held_ovf = 1'b0;
    longint unsigned es;
    bit              eo;
    forever begin
      @(negedge CLK);
      if (RST) begin
        held = 0;
      end else begin
        if (held) begin
          check("hold_valid", OUT_VALID, 1);
          check("hold_stable_sum", OUT_SUM, held_sum);
          check("hold_stable_ovf", OUT_OVF, held_ovf);
        end
        held     = OUT_VALID && !OUT_READY;
        held_sum = OUT_SUM;
        held_ovf = OUT_OVF;
        if (OUT_VALID && OUT_READY) begin
          n_out++;
          if (exp_sum_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            es = exp_sum_q.pop_front();
            eo = exp_ovf_q.pop_front();
            check("out_sum", OUT_SUM, es);
            check("out_ovf", OUT_OVF, eo);
          end
        end
      end
    end
  endtask

  initial begin
    logic [CNT_W-1:0] len;
    int               n;
    int               t;
    logic [25:0]      s;

    RST = 1'b1; IN_VALID = 1'b0; IN_S = '0; LEN = '0; OUT_READY = 1'b1;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_sum", OUT_SUM, 0);
    check("rst_out_ovf", OUT_OVF, 0);
    check("rst_busy", BUSY, 0);
    RST = 1'b0;
    tick();

    // LEN=3, back-to-back 1,2,3
    send(26'd1, 8'd3);
    send(26'd2, 8'd3);
    check("b2b_not_yet_valid", OUT_VALID, 0);
    send(26'd3, 8'd3);
    check("b2b_latency_valid", OUT_VALID, 1);
    check("b2b_sum_now", OUT_SUM, 6);
    tick();
    check("b2b_idle_ready", IN_READY, 1);
    check("b2b_idle_busy", BUSY, 0);

    // LEN=0 behaves as LEN=1
    send(26'h3FFFFFF, 8'd0);
    check("len0_latency_valid", OUT_VALID, 1);
    check("len0_sum", OUT_SUM, 26'h3FFFFFF);
    tick();

    // Output stall for 5 cycles, then a sum offered in the release cycle
    OUT_READY = 1'b0;
    send(26'd7, 8'd2);
    send(26'd9, 8'd2);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", OUT_VALID, 1);
      check("stall_sum", OUT_SUM, 16);
      check("stall_in_ready", IN_READY, 0);
      tick();
    end
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; IN_S = 26'd99; LEN = 8'd1;
    tick();
    check("release_not_accepted_busy", BUSY, 0);
    check("release_idle_ready", IN_READY, 1);
    tick();
    model_accept(26'd99, 8'd1);
    IN_VALID = 1'b0;
    check("after_release_valid", OUT_VALID, 1);
    check("after_release_sum", OUT_SUM, 99);
    tick();

    // Overflow on a 26-bit accumulator
    send(26'h3FFFFFF, 8'd2);
    send(26'h2, 8'd2);
`ifdef ADDER_RESULT_ACCUMULATOR_SATURATE_EN
    check("ovf_sum_sat", OUT_SUM, 26'h3FFFFFF);
`else
    check("ovf_sum_wrap", OUT_SUM, 26'h1);
`endif
    check("ovf_flag", OUT_OVF, 1);
    tick();

    // Reset in mid-block discards it
    send(26'd10, 8'd4);
    send(26'd20, 8'd4);
    check("partial_acc", OUT_SUM, 30);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m_cnt = 0;
    check("midrst_valid", OUT_VALID, 0);
    check("midrst_sum", OUT_SUM, 0);
    check("midrst_busy", BUSY, 0);
    send(26'd5, 8'd1);
    check("midrst_next_sum", OUT_SUM, 5);
    check("midrst_next_ovf", OUT_OVF, 0);
    tick();

    // Input gap leaves the accumulator untouched
    send(26'd4, 8'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("gap_acc_hold", OUT_SUM, 4);
      check("gap_busy", BUSY, 1);
    end
    send(26'd5, 8'd3);
    send(26'd6, 8'd3);
    check("gap_total", OUT_SUM, 15);
    tick();

    // Randomized blocks with random output stalls and input gaps
    rand_mode = 1;
    for (int b = 0; b < 40; b++) begin
      len = CNT_W'($urandom_range(0, 5));
      n = (len == 0) ? 1 : int'(len);
      for (int i = 0; i < n; i++) begin
        s = ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'($urandom_range(0, 1000));
        send(s, (i == 0) ? len : CNT_W'($urandom));
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    // Drain remaining results
    rand_mode = 0;
    OUT_READY = 1'b1;
    t = 0;
    while (exp_sum_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    tick();
    check("drain_queue_empty", exp_sum_q.size(), 0);
    check("output_count", n_out, n_pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
